// File: rtl/lane_merge_scheduler.sv
// Merges two input lanes into one output stream in strict alternation:
// lane 0 word k, lane 1 word k, lane 0 word k+1, and so on.
// Each lane is buffered in its own DEPTH-word FIFO. The first word leaves only
// once both lanes hold data. A write to a full FIFO with no pop on that FIFO is
// dropped, sets that lane's sticky overflow flag and parks the block in ERR.
// ERR is left only through flush or reset.
//
// Ports:
//   clk_2f      block clock, rising edge
//   reset_L     asynchronous active-low reset
//   lane_0/1    lane words, sampled when valid_0/1 = 1
//   valid_0/1   lane word present this cycle
//   out_ready   downstream accepts data_out this cycle
//   flush       synchronous clear of FIFOs, flags and FSM; wins over everything
//   data_out    merged word (registered)
//   valid_out   data_out holds a valid word (registered)
//   fill_0/1    per-lane FIFO occupancy
//   overflow_0/1 sticky per-lane overflow flags
//   state       FSM encoding: IDLE=0, L0=1, L1=2, ERR=3
module lane_merge_scheduler #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_2f,
    input  logic                   reset_L,
    input  logic [DW-1:0]          lane_0,
    input  logic                   valid_0,
    input  logic [DW-1:0]          lane_1,
    input  logic                   valid_1,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [DW-1:0]          data_out,
    output logic                   valid_out,
    output logic [$clog2(DEPTH):0] fill_0,
    output logic [$clog2(DEPTH):0] fill_1,
    output logic                   overflow_0,
    output logic                   overflow_1,
    output logic [1:0]             state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StL0   = 2'd1,
        StL1   = 2'd2,
        StErr  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [1:0]    ovf_q, ovf_d;

    logic [DW-1:0] mem [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [FW-1:0] fill_q [2];
    logic [FW-1:0] fill_d [2];

    logic [DW-1:0] din [2];
    logic [1:0]    vin;
    logic [1:0]    pop;
    logic [1:0]    wr_en;
    logic [1:0]    ovf_hit;
    logic          slot_free;
    logic          in_err;

    assign din[0] = lane_0;
    assign din[1] = lane_1;
    assign vin    = {valid_1, valid_0};

    // Output slot can take a new word when empty or being drained this cycle.
    assign slot_free = !valid_q || out_ready;
    assign in_err    = (state_q == StErr);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = '0;

        // Pop decisions look only at registered fills, never at this cycle's writes.
        unique case (state_q)
            StIdle: begin
                if (slot_free) begin
                    valid_d = 1'b0;
                    if (fill_q[0] != '0 && fill_q[1] != '0) begin
                        pop[0]  = 1'b1;
                        data_d  = mem[0][rd_ptr_q[0]];
                        valid_d = 1'b1;
                        state_d = StL1;
                    end
                end
            end
            StL0: begin
                if (slot_free) begin
                    if (fill_q[0] != '0) begin
                        pop[0]  = 1'b1;
                        data_d  = mem[0][rd_ptr_q[0]];
                        valid_d = 1'b1;
                        state_d = StL1;
                    end else begin
                        // Wait on lane 0 rather than skipping ahead to lane 1.
                        valid_d = 1'b0;
                    end
                end
            end
            StL1: begin
                if (slot_free) begin
                    if (fill_q[1] != '0) begin
                        pop[1]  = 1'b1;
                        data_d  = mem[1][rd_ptr_q[1]];
                        valid_d = 1'b1;
                        state_d = StL0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            StErr: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // A full FIFO still accepts a write when it is popped at the same edge.
        for (int i = 0; i < 2; i++) begin
            wr_en[i]    = vin[i] && !in_err && ((fill_q[i] != FULL) || pop[i]);
            ovf_hit[i]  = vin[i] && !in_err && (fill_q[i] == FULL) && !pop[i];
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_en[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            fill_d[i]   = fill_q[i] + FW'(wr_en[i]) - FW'(pop[i]);
        end
        ovf_d = ovf_q | ovf_hit;

        if (|ovf_hit) begin
            state_d = StErr;
            valid_d = 1'b0;
        end

        if (flush) begin
            wr_en   = '0;
            ovf_d   = '0;
            valid_d = 1'b0;
            state_d = StIdle;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                fill_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                fill_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                fill_q[i]   <= fill_d[i];
            end
        end
    end

    // Storage is never reset; fill counters gate every read.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr_q[i]] <= din[i];
            end
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign fill_0     = fill_q[0];
    assign fill_1     = fill_q[1];
    assign overflow_0 = ovf_q[0];
    assign overflow_1 = ovf_q[1];
    assign state      = state_q;

endmodule

// File: doc/lane_merge_scheduler.md
LANE_MERGE_SCHEDULER -- requirements
Module: lane_merge_scheduler

Interface
REQ-001 Parameter DW, default 32, width of each lane word and of data_out.
REQ-002 Parameter DEPTH, default 4, per-lane FIFO depth in words; power of two, at least 2.
REQ-003 clk_2f  input  1  single block clock, all sequential logic on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 lane_0  input  DW  lane 0 word, sampled when valid_0=1.
REQ-006 valid_0  input  1  lane 0 word present this cycle.
REQ-007 lane_1  input  DW  lane 1 word, sampled when valid_1=1.
REQ-008 valid_1  input  1  lane 1 word present this cycle.
REQ-009 out_ready  input  1  downstream accepts data_out this cycle.
REQ-010 flush  input  1  synchronous clear of FIFOs, flags and FSM.
REQ-011 data_out  output  DW  merged word stream, registered.
REQ-012 valid_out  output  1  data_out holds a valid word, registered.
REQ-013 fill_0, fill_1  output  log2(DEPTH)+1  current occupancy of each lane FIFO.
REQ-014 overflow_0, overflow_1  output  1  sticky per-lane overflow flag.
REQ-015 state  output  2  FSM state encoding: IDLE=0, L0=1, L1=2, ERR=3.

Function
REQ-016 Each lane SHALL own a DEPTH-word FIFO; valid_x=1 with FIFO not full SHALL write lane_x at that edge, and fill_x SHALL increment at that edge.
REQ-017 A FIFO write and pop in the same cycle SHALL leave fill_x unchanged; a write to a full FIFO in the same cycle as a pop on that FIFO SHALL be accepted without overflow.
REQ-018 A write to a full FIFO without a pop SHALL drop the word, set overflow_x, and move the FSM to ERR at the same edge.
REQ-019 The output slot SHALL be free when valid_out=0 or out_ready=1; while valid_out=1 and out_ready=0, data_out and valid_out SHALL hold unchanged.
REQ-020 IDLE: when fill_0>0, fill_1>0 and the slot is free, the block SHALL pop FIFO 0 into data_out, set valid_out=1, and go to L1; otherwise it SHALL stay in IDLE.
REQ-021 L0: when fill_0>0 and the slot is free, the block SHALL pop FIFO 0 into data_out, set valid_out=1, and go to L1.
REQ-022 L1: when fill_1>0 and the slot is free, the block SHALL pop FIFO 1 into data_out, set valid_out=1, and go to L0.
REQ-023 In L0/L1, when the slot is free and the selected FIFO is empty, the block SHALL set valid_out=0 and keep the state; it SHALL never skip a lane.
REQ-024 Output order SHALL be strictly lane0 word k, lane1 word k, lane0 word k+1, and so on; pop decisions SHALL use fill values registered before the edge.
REQ-025 Minimum latency: a lane_0 word written at edge N into an empty FIFO while in L0 with a free slot SHALL appear on data_out after edge N+1.
REQ-026 ERR: valid_out SHALL be 0, all lane writes SHALL be ignored, and the state SHALL remain ERR until flush or reset.
REQ-027 flush=1 SHALL take priority over all other activity at that edge: both FIFOs emptied, overflow flags cleared, valid_out=0, state=IDLE; lane inputs in a flush cycle SHALL be discarded.
REQ-028 Simultaneous overflow on both lanes SHALL set both overflow flags in the same edge.

Reset
REQ-029 reset_L=0 SHALL immediately and asynchronously force: data_out=0, valid_out=0, fill_0=fill_1=0, overflow_0=overflow_1=0, state=IDLE, FIFO pointers=0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; after release, the first output SHALL again be a lane 0 word, taken only once both lanes hold data.
REQ-031 FIFO storage contents need no reset; no output SHALL depend on unwritten storage.

Verification
REQ-032 Aligned stream: out_ready=1; lane_0 = A0,A1,A2 and lane_1 = B0,B1,B2, both valid on the same three edges -> data_out = A0,B0,A1,B1,A2,B2 on consecutive cycles, first word after the edge following the first write.
REQ-033 Skew: lane_1 delayed 3 cycles relative to lane_0 (words 0x11,0x22 / 0xAA,0xBB) -> state stays IDLE until 0xAA is written, then output is 0x11,0xAA,0x22,0xBB with no gaps once aligned.
REQ-034 Backpressure: out_ready=0 for 5 cycles after the first output 0x11 -> data_out holds 0x11 with valid_out=1; no word is lost; fill_0 never exceeds DEPTH with compliant input.
REQ-035 Overflow: out_ready=0, six valid_0 words, no valid_1 -> fill_0=4, overflow_0=1 on the 5th write, state=ERR, valid_out=0; one flush cycle -> fill_0=0, overflow_0=0, state=IDLE.
REQ-036 Full plus pop: fill_0=4 in L0, out_ready=1, valid_0=1 with 0x55 -> no overflow, fill_0 stays 4, 0x55 appears later in order.
REQ-037 Async reset: assert reset_L=0 between clock edges mid-stream -> all outputs at reset values before the next edge; the stream restarts with a lane 0 word.
